// File: rtl/seq_debug_cmd_master_if.sv
// Avalon-MM bus between the debug command master and the sequencer command mailbox.
interface seq_debug_cmd_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_read;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_read,
        input  avm_readdata,
        input  avm_readdatavalid,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_read,
        output avm_readdata,
        output avm_readdatavalid,
        output avm_waitrequest
    );
endinterface

// File: rtl/seq_debug_cmd_master.sv
// Debug command master: writes the sequencer mailbox, triggers a command, polls the
// status word until it turns nonzero or the poll budget runs out, then returns one response.
module seq_debug_cmd_master #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] CMD_BASE   = ADDR_W'(32'h000153bc),
    parameter int                MAX_PARAMS = 4,
    parameter int                POLL_GAP   = 16,
    parameter int                MAX_POLLS  = 1024
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [31:0]             cmd_code,
    input  logic [32*MAX_PARAMS-1:0] cmd_params,
    input  logic [2:0]              cmd_nparams,

    output logic                    rsp_valid,
    output logic [31:0]             rsp_status,
    output logic                    rsp_timeout,

    seq_debug_cmd_master_if.master  avm
);

    localparam int POLL_W = $clog2(MAX_POLLS + 1);
    localparam int GAP_W  = $clog2(POLL_GAP + 1);

    localparam logic [ADDR_W-1:0] REQ_CMD    = CMD_BASE;
    localparam logic [ADDR_W-1:0] CMD_STATUS = CMD_BASE + ADDR_W'(4);
    localparam logic [ADDR_W-1:0] CMD_PARAMS = CMD_BASE + ADDR_W'(8);
    localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(MAX_POLLS);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(POLL_GAP - 1);
    localparam logic [2:0]        NPARAM_MAX = 3'(MAX_PARAMS);

    typedef enum logic [2:0] {
        IDLE,
        WR_CLR,
        WR_PARAM,
        WR_CMD,
        RD_STAT,
        WAIT_RD,
        GAP,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_d;

    logic [31:0]             code_q;
    logic [32*MAX_PARAMS-1:0] params_q;
    logic [2:0]              nparams_q;
    logic [2:0]              nparams_clamped;
    logic [2:0]              idx_q;
    logic [2:0]              idx_d;
    logic [POLL_W-1:0]       poll_q;
    logic [POLL_W-1:0]       poll_d;
    logic [GAP_W-1:0]        gap_q;
    logic [GAP_W-1:0]        gap_d;
    logic [31:0]             status_d;
    logic                    timeout_d;
    logic [31:0]             param_word;
    logic                    accept;

    assign nparams_clamped = (cmd_nparams > NPARAM_MAX) ? NPARAM_MAX : cmd_nparams;

    always_comb begin
        param_word = '0;
        for (int i = 0; i < MAX_PARAMS; i++) begin
            if (idx_q == 3'(i)) begin
                param_word = params_q[32*i +: 32];
            end
        end
    end

    // Bus outputs depend only on state, so they stay put while waitrequest stalls a transfer.
    always_comb begin
        state_d           = state;
        idx_d             = idx_q;
        poll_d            = poll_q;
        gap_d             = gap_q;
        status_d          = rsp_status;
        timeout_d         = rsp_timeout;
        accept            = 1'b0;
        cmd_ready         = 1'b0;
        rsp_valid         = 1'b0;
        avm.avm_address   = '0;
        avm.avm_write     = 1'b0;
        avm.avm_writedata = '0;
        avm.avm_read      = 1'b0;

        if (!reset) begin
            case (state)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        accept  = 1'b1;
                        idx_d   = '0;
                        poll_d  = '0;
                        state_d = WR_CLR;
                    end
                end

                WR_CLR: begin
                    avm.avm_address   = CMD_STATUS;
                    avm.avm_write     = 1'b1;
                    avm.avm_writedata = '0;
                    if (!avm.avm_waitrequest) begin
                        state_d = (nparams_q != 3'd0) ? WR_PARAM : WR_CMD;
                    end
                end

                WR_PARAM: begin
                    avm.avm_address   = CMD_PARAMS + ADDR_W'({idx_q, 2'b00});
                    avm.avm_write     = 1'b1;
                    avm.avm_writedata = param_word;
                    if (!avm.avm_waitrequest) begin
                        if (idx_q == nparams_q - 3'd1) begin
                            state_d = WR_CMD;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end

                WR_CMD: begin
                    avm.avm_address   = REQ_CMD;
                    avm.avm_write     = 1'b1;
                    avm.avm_writedata = code_q;
                    if (!avm.avm_waitrequest) begin
                        state_d = RD_STAT;
                    end
                end

                RD_STAT: begin
                    avm.avm_address = CMD_STATUS;
                    avm.avm_read    = 1'b1;
                    if (!avm.avm_waitrequest) begin
                        poll_d  = (poll_q == POLL_LIMIT) ? poll_q : poll_q + POLL_W'(1);
                        state_d = WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    if (avm.avm_readdatavalid) begin
                        if (avm.avm_readdata != 32'd0) begin
                            status_d  = avm.avm_readdata;
                            timeout_d = 1'b0;
                            state_d   = DONE;
                        end else if (poll_q >= POLL_LIMIT) begin
                            status_d  = 32'd0;
                            timeout_d = 1'b1;
                            state_d   = DONE;
                        end else begin
                            gap_d   = '0;
                            state_d = GAP;
                        end
                    end
                end

                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = RD_STAT;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end

                DONE: begin
                    rsp_valid = 1'b1;
                    state_d   = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Command fields are captured once at acceptance; the host may change its inputs afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            code_q      <= '0;
            params_q    <= '0;
            nparams_q   <= '0;
            idx_q       <= '0;
            poll_q      <= '0;
            gap_q       <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            idx_q       <= idx_d;
            poll_q      <= poll_d;
            gap_q       <= gap_d;
            rsp_status  <= status_d;
            rsp_timeout <= timeout_d;
            if (accept) begin
                code_q    <= cmd_code;
                params_q  <= cmd_params;
                nparams_q <= nparams_clamped;
            end
        end
    end

endmodule

// File: tb/tb_seq_debug_cmd_master.sv
// Self-checking bench for seq_debug_cmd_master: an Avalon slave model with a status script,
// scoreboards for mailbox writes and responses, and a mid-read reset scenario.
`timescale 1ns/1ps
module tb_seq_debug_cmd_master;

    localparam int ADDR_W     = 32;
    localparam int MAX_PARAMS = 4;
    localparam int POLL_GAP   = 16;
    localparam int MAX_POLLS  = 8;
    localparam logic [31:0] CMD_BASE   = 32'h000153bc;
    localparam logic [31:0] REQ_CMD    = CMD_BASE;
    localparam logic [31:0] CMD_STATUS = CMD_BASE + 32'd4;
    localparam logic [31:0] CMD_PARAMS = CMD_BASE + 32'd8;

    typedef struct {
        logic [31:0] status;
        logic        timeout;
        int          latency;
    } rsp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  cmd_code = '0;
    logic [127:0] cmd_params = '0;
    logic [2:0]   cmd_nparams = '0;
    logic         rsp_valid;
    logic [31:0]  rsp_status;
    logic         rsp_timeout;

    seq_debug_cmd_master_if #(.ADDR_W(ADDR_W)) avm_bus ();

    seq_debug_cmd_master #(
        .ADDR_W     (ADDR_W),
        .CMD_BASE   (CMD_BASE),
        .MAX_PARAMS (MAX_PARAMS),
        .POLL_GAP   (POLL_GAP),
        .MAX_POLLS  (MAX_POLLS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_params  (cmd_params),
        .cmd_nparams (cmd_nparams),
        .rsp_valid   (rsp_valid),
        .rsp_status  (rsp_status),
        .rsp_timeout (rsp_timeout),
        .avm         (avm_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int assertCount = 0;
    int failCount   = 0;

    logic [63:0] expWrQ[$];
    rsp_t        expRspQ[$];
    logic [31:0] statusQ[$];

    logic        stallEn = 1'b0;
    int          rdLat = 1;
    int          rdCnt = 0;
    int          readsSeen = 0;
    int          lastReadCyc = 0;
    int          minGap = 1000000;
    int          acceptCyc = 0;
    int          rspCount = 0;
    logic        prevStalled = 1'b0;
    logic        prevRsp = 1'b0;
    logic [31:0] prevAddr = '0;
    logic [31:0] prevData = '0;
    logic        prevWr = 1'b0;
    logic        prevRd = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model and monitors run mid-cycle, well away from the active edge.
    always begin
        logic [63:0] expWr;
        rsp_t        expRsp;
        @(negedge clk);
        #1;
        if (prevStalled && !reset) begin
            checkOutput("hold_addr", avm_bus.avm_address, prevAddr);
            checkOutput("hold_data", avm_bus.avm_writedata, prevData);
            checkOutput("hold_ctrl", {avm_bus.avm_write, avm_bus.avm_read}, {prevWr, prevRd});
        end

        avm_bus.avm_readdatavalid = 1'b0;
        avm_bus.avm_readdata      = 32'hDEAD_BEEF;
        if (rdCnt > 0) begin
            rdCnt--;
            if (rdCnt == 0) begin
                avm_bus.avm_readdatavalid = 1'b1;
                if (statusQ.size() > 0) avm_bus.avm_readdata = statusQ.pop_front();
                else                    avm_bus.avm_readdata = 32'd0;
            end
        end
        avm_bus.avm_waitrequest = stallEn ? ($urandom_range(0, 1) == 1) : 1'b0;

        checkOutput("rd_wr_excl", {63'd0, avm_bus.avm_write & avm_bus.avm_read}, 64'd0);

        if (!reset && avm_bus.avm_write && !avm_bus.avm_waitrequest) begin
            if (expWrQ.size() > 0) expWr = expWrQ.pop_front();
            else                   expWr = 64'hFFFF_FFFF_FFFF_FFFF;
            checkOutput("wr_addr", avm_bus.avm_address, expWr[63:32]);
            checkOutput("wr_data", avm_bus.avm_writedata, expWr[31:0]);
        end

        if (!reset && avm_bus.avm_read && !avm_bus.avm_waitrequest) begin
            checkOutput("rd_addr", avm_bus.avm_address, CMD_STATUS);
            if (readsSeen > 0 && (cyc - lastReadCyc) < minGap) minGap = cyc - lastReadCyc;
            readsSeen++;
            lastReadCyc = cyc;
            rdCnt = rdLat;
        end

        if (cmd_valid && cmd_ready) acceptCyc = cyc;

        if (rsp_valid) begin
            checkOutput("rsp_single", {63'd0, prevRsp}, 64'd0);
            checkOutput("rdy_in_done", {63'd0, cmd_ready}, 64'd0);
            if (expRspQ.size() > 0) expRsp = expRspQ.pop_front();
            else expRsp = '{status: 32'hFFFF_FFFF, timeout: 1'b1, latency: -1};
            checkOutput("rsp_status", rsp_status, expRsp.status);
            checkOutput("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, expRsp.timeout});
            if (expRsp.latency >= 0) checkOutput("rsp_latency", cyc - acceptCyc, expRsp.latency);
            rspCount++;
        end

        prevRsp     = rsp_valid;
        prevStalled = !reset && (avm_bus.avm_write || avm_bus.avm_read) && avm_bus.avm_waitrequest;
        prevAddr    = avm_bus.avm_address;
        prevData    = avm_bus.avm_writedata;
        prevWr      = avm_bus.avm_write;
        prevRd      = avm_bus.avm_read;
    end

    task automatic driveCommand(input logic [31:0] code, input logic [2:0] np, input logic [127:0] params);
        int waitCyc;
        waitCyc = 0;
        @(negedge clk);
        while (!cmd_ready && waitCyc < 200) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("ready_wait", {63'd0, cmd_ready}, 64'd1);
        cmd_valid   = 1'b1;
        cmd_code    = code;
        cmd_nparams = np;
        cmd_params  = params;
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_code    = $urandom;
        cmd_params  = {$urandom, $urandom, $urandom, $urandom};
        checkOutput("busy_after_acc", {63'd0, cmd_ready}, 64'd0);
    endtask

    // Caller loads statusQ with the status script before calling.
    task automatic applyStimulus(input logic [31:0] code, input logic [2:0] np, input logic [127:0] params);
        int          clamped;
        int          reads;
        int          startCount;
        int          waitCyc;
        logic [31:0] st;
        logic        to;
        rsp_t        r;

        clamped = (np > 3'd4) ? 4 : int'(np);
        expWrQ.push_back({CMD_STATUS, 32'd0});
        for (int i = 0; i < clamped; i++) expWrQ.push_back({CMD_PARAMS + 32'(4*i), params[32*i +: 32]});
        expWrQ.push_back({REQ_CMD, code});

        reads = MAX_POLLS;
        st    = 32'd0;
        to    = 1'b1;
        for (int i = 0; i < MAX_POLLS; i++) begin
            if (i < statusQ.size() && statusQ[i] != 32'd0) begin
                reads = i + 1;
                st    = statusQ[i];
                to    = 1'b0;
                break;
            end
        end
        r.status  = st;
        r.timeout = to;
        r.latency = stallEn ? -1 : clamped + 5 + (reads - 1) * (POLL_GAP + 2);
        expRspQ.push_back(r);

        readsSeen  = 0;
        minGap     = 1000000;
        startCount = rspCount;
        driveCommand(code, np, params);

        waitCyc = 0;
        while (rspCount == startCount && waitCyc < 600) begin
            @(negedge clk);
            #2;
            waitCyc++;
        end
        checkOutput("rsp_seen", rspCount - startCount, 1);
        checkOutput("read_count", readsSeen, reads);
        if (reads > 1) checkOutput("poll_spacing", {63'd0, minGap >= POLL_GAP + 1}, 64'd1);
        @(negedge clk);
        checkOutput("ready_after", {63'd0, cmd_ready}, 64'd1);
        checkOutput("rsp_hold", rsp_status, st);
        checkOutput("wr_drained", expWrQ.size(), 0);
        statusQ.delete();
    endtask

    task automatic resetDuringRead();
        int startCount;
        int waitCyc;
        expWrQ.push_back({CMD_STATUS, 32'd0});
        expWrQ.push_back({REQ_CMD, 32'h2});
        statusQ.push_back(32'h9);
        rdLat      = 2;
        readsSeen  = 0;
        startCount = rspCount;
        driveCommand(32'h2, 3'd0, '0);

        waitCyc = 0;
        while (readsSeen == 0 && waitCyc < 100) begin
            @(negedge clk);
            #2;
            waitCyc++;
        end
        checkOutput("rst_read_seen", readsSeen, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_read_low", {63'd0, avm_bus.avm_read}, 64'd0);
        checkOutput("rst_write_low", {63'd0, avm_bus.avm_write}, 64'd0);
        repeat (40) @(negedge clk);
        checkOutput("rst_no_rsp", rspCount - startCount, 0);
        checkOutput("rst_ready", {63'd0, cmd_ready}, 64'd1);
        checkOutput("rst_status", rsp_status, 32'd0);
        checkOutput("rst_reads", readsSeen, 1);
        checkOutput("rst_wr_drained", expWrQ.size(), 0);
        rdLat = 1;
        statusQ.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        avm_bus.avm_waitrequest   = 1'b0;
        avm_bus.avm_readdatavalid = 1'b0;
        avm_bus.avm_readdata      = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        checkOutput("rst_avm_write", {63'd0, avm_bus.avm_write}, 64'd0);
        checkOutput("rst_avm_read", {63'd0, avm_bus.avm_read}, 64'd0);
        checkOutput("rst_avm_addr", avm_bus.avm_address, 32'd0);
        checkOutput("rst_avm_wdata", avm_bus.avm_writedata, 32'd0);
        checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_rsp_status", rsp_status, 32'd0);
        checkOutput("rst_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready_after", {63'd0, cmd_ready}, 64'd1);

        $display("[TB] basic two-parameter command");
        statusQ.push_back(32'h3);
        applyStimulus(32'h1, 3'd2, {64'd0, 32'hB, 32'hA});

        $display("[TB] zero and clamped parameter counts");
        statusQ.push_back(32'h22);
        applyStimulus(32'h11, 3'd0, {32'h4, 32'h3, 32'h2, 32'h1});
        statusQ.push_back(32'h44);
        applyStimulus(32'h33, 3'd7, {32'hD4, 32'hC3, 32'hB2, 32'hA1});

        $display("[TB] polling with gaps");
        statusQ.push_back(32'h0);
        statusQ.push_back(32'h0);
        statusQ.push_back(32'h0);
        statusQ.push_back(32'h5);
        applyStimulus(32'h55, 3'd1, {96'd0, 32'h1234_5678});

        $display("[TB] poll budget exhausted");
        applyStimulus(32'h66, 3'd0, '0);

        $display("[TB] random waitrequest stalls");
        stallEn = 1'b1;
        statusQ.push_back(32'h3);
        applyStimulus(32'h1, 3'd2, {64'd0, 32'hB, 32'hA});
        statusQ.push_back(32'h0);
        statusQ.push_back(32'h7);
        applyStimulus(32'h77, 3'd4, {32'h44, 32'h33, 32'h22, 32'h11});
        stallEn = 1'b0;
        @(negedge clk);

        $display("[TB] reset while waiting for read data");
        resetDuringRead();
        statusQ.push_back(32'hA5);
        applyStimulus(32'h88, 3'd3, {32'd0, 32'hC, 32'hB, 32'hA});

        checkOutput("rsp_q_drained", expRspQ.size(), 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/seq_debug_cmd_master.md
# seq_debug_cmd_master

Avalon-MM master that issues debug commands to the LPDDR2 sequencer core's command mailbox and returns the completion status. It sits directly upstream of the sequencer core debug region: a host-side controller (memory test FSM) presents a command code plus up to four parameters, and this block writes the mailbox, triggers the command, polls the status word until completion or timeout, and hands back a single response. One command is in flight at a time.

## Interface
Parameters:
- `ADDR_W`, 32: Avalon byte-address width.
- `CMD_BASE`, 'h000153bc: mailbox base. `REQ_CMD` = CMD_BASE+0, `CMD_STATUS` = CMD_BASE+4, `CMD_PARAMS` = CMD_BASE+8 (param i at CMD_PARAMS+4*i).
- `MAX_PARAMS`, 4: parameter slots supported.
- `POLL_GAP`, 16: idle cycles between status reads (≥1).
- `MAX_POLLS`, 1024: status reads before declaring timeout.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block idle, can accept.
- `cmd_code` in 32: value written to REQ_CMD.
- `cmd_params` in 32*MAX_PARAMS: param i in bits [32i+31:32i].
- `cmd_nparams` in 3: number of params to write; values >MAX_PARAMS clamp to MAX_PARAMS.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_status` out 32: final CMD_STATUS value (0 on timeout).
- `rsp_timeout` out 1: qualifies rsp_valid; 1 = MAX_POLLS exhausted.
- `avm_address` out ADDR_W; `avm_write` out 1; `avm_writedata` out 32; `avm_read` out 1.
- `avm_readdata` in 32; `avm_readdatavalid` in 1; `avm_waitrequest` in 1.

## Operation
- States: IDLE, WR_CLR, WR_PARAM, WR_CMD, RD_STAT, WAIT_RD, GAP, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register cmd_code, cmd_params, clamped nparams; clear param index and poll counter; go WR_CLR.
- WR_CLR: write 0 to CMD_STATUS. Then WR_PARAM if nparams>0, else WR_CMD.
- WR_PARAM: write param[idx] to CMD_PARAMS+4*idx; idx increments per accepted write; after idx=nparams-1 go WR_CMD.
- WR_CMD: write cmd_code to REQ_CMD; go RD_STAT.
- RD_STAT: assert avm_read at CMD_STATUS; on acceptance increment poll counter, go WAIT_RD.
- WAIT_RD: on readdatavalid: data≠0 → capture as status, DONE. data=0 and poll counter=MAX_POLLS → status=0, timeout=1, DONE. Otherwise GAP.
- GAP: count POLL_GAP cycles, then RD_STAT.
- DONE: rsp_valid=1 for exactly one cycle; return to IDLE.
- Avalon rule: a transfer completes in the cycle avm_write/avm_read is high and avm_waitrequest low; address, writedata, write/read held stable while waitrequest high. Never more than one outstanding read. avm_read and avm_write never high together.
- readdatavalid outside WAIT_RD is ignored.

## Timing
- Reset values: cmd_ready=0 during reset cycle, 1 the cycle after; rsp_valid=0, rsp_status=0, rsp_timeout=0, avm_write=0, avm_read=0, avm_address=0, avm_writedata=0; state IDLE.
- Reset mid-operation: next cycle avm_read/avm_write deasserted, state IDLE, no response issued; late readdatavalid ignored.
- Latency (waitrequest=0, read latency 1, status nonzero on first read), accept at cycle 0: WR_CLR cycle 1; params cycles 2..n+1; WR_CMD cycle n+2; read cycle n+3; readdatavalid n+4; rsp_valid n+5.
- Each waitrequest cycle extends the current state by one cycle.
- cmd_ready=0 from cycle after acceptance through DONE; back-to-back: next command accepted the cycle after rsp_valid.
- Counters: param index 3 bits; poll counter $clog2(MAX_POLLS+1) bits, saturates; gap counter $clog2(POLL_GAP+1) bits.
- rsp_status/rsp_timeout hold their value until the next DONE.

## Test plan
- Reset then cmd_code='h1, nparams=2, params 'hA,'hB, status returns 'h3 first read → writes (STATUS←0, PARAMS←'hA, PARAMS+4←'hB, REQ_CMD←'h1), rsp_valid at cycle 7, rsp_status='h3, timeout=0.
- nparams=0 and nparams=7 → no param writes vs. exactly 4 param writes at PARAMS..PARAMS+12.
- Status 0 for 3 reads then 'h5, POLL_GAP=16 → 4 reads spaced ≥17 cycles, rsp_status='h5.
- Status always 0, MAX_POLLS=8 → exactly 8 reads, rsp_valid with rsp_timeout=1, rsp_status=0.
- Random waitrequest stalls (50%) → all address/data held stable while stalled, same write sequence and response as unstalled run.
- Reset asserted during WAIT_RD, readdatavalid arrives next cycle → no rsp_valid, cmd_ready=1 afterward, next command completes normally.
